traffic_sequencer: RTL and testbench

Parametrised intersection sequencer for `N_LIGHTS` signal heads, with configurable green, yellow and all-red clearance durations. Exactly one head is green or yellow at a time; all others are held red. Beyond a plain rotation it adds:
- per-head force-red skip;
- preferential (emergency/bus) preemption with a minimum-green guarantee;
- a flashing-yellow attention mode.

It sits between the system timebase and the per-head lamp drivers, replacing fixed four-head sequencing.

---
 rtl/traffic_sequencer.sv | 165 ++++++++++++++++
 tb/tb_traffic_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sequencer.sv
// traffic_sequencer: one-green-at-a-time intersection sequencer with force-red skip,
// preferential preemption behind a minimum-green guarantee, and flashing-yellow attention mode.
module traffic_sequencer #(
  parameter int N_LIGHTS        = 4,
  parameter int GREEN_TICKS     = 8,
  parameter int MIN_GREEN_TICKS = 3,
  parameter int YELLOW_TICKS    = 3,
  parameter int CLEAR_TICKS     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick,
  input  logic                        attention,
  input  logic [N_LIGHTS-1:0]         force_reds,
  input  logic [N_LIGHTS-1:0]         preferentials,
  output logic [3*N_LIGHTS-1:0]       leds,
  output logic [$clog2(N_LIGHTS)-1:0] active,
  output logic [2:0]                  phase
);

  localparam int AW = $clog2(N_LIGHTS);
  localparam int GY_MAX = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_TICKS = (GY_MAX > CLEAR_TICKS) ? GY_MAX : CLEAR_TICKS;
  localparam int TW = $clog2(MAX_TICKS) + 1;

  localparam logic [TW-1:0] GREEN_END  = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] MIN_END    = TW'(MIN_GREEN_TICKS - 1);
  localparam logic [TW-1:0] YELLOW_END = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] CLEAR_END  = TW'(CLEAR_TICKS - 1);

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_FLASH  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t                r_state, w_state_next;
  logic [AW-1:0]         r_active, w_active_next;
  logic [TW-1:0]         r_timer, w_timer_next;
  logic                  r_flash, w_flash_next;
  logic [3*N_LIGHTS-1:0] r_leds, w_leds_next;

  logic [N_LIGHTS-1:0]   w_pref_ok;
  logic [N_LIGHTS-1:0]   w_active_oh;
  logic                  w_preempt;
  logic                  w_any_free;
  logic                  w_pick_valid;
  logic [AW-1:0]         w_pick;
  logic [AW-1:0]         w_rr;

  genvar gi;
  generate
    for (gi = 0; gi < N_LIGHTS; gi++) begin : g_head
      assign w_pref_ok[gi]   = preferentials[gi] & ~force_reds[gi];
      assign w_active_oh[gi] = (r_active == AW'(gi));
      // Lamp image is derived from the next state so it lands in the same cycle as phase/active.
      assign w_leds_next[3*gi +: 3] =
          (w_state_next == S_FLASH)                                    ? {1'b0, w_flash_next, 1'b0} :
          (w_active_next != AW'(gi))                                   ? 3'b100 :
          (w_state_next == S_GREEN)                                    ? 3'b001 :
          (w_state_next == S_YELLOW)                                   ? 3'b010 : 3'b100;
    end
  endgenerate

  assign w_preempt  = |(w_pref_ok & ~w_active_oh);
  assign w_any_free = ~&force_reds;

  // Next green: lowest preferential wins, else first non-forced head after active (may wrap to itself).
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = '0;
    w_rr         = r_active;
    for (int k = N_LIGHTS - 1; k >= 0; k--) begin
      if (w_pref_ok[AW'(k)]) begin
        w_pick_valid = 1'b1;
        w_pick       = AW'(k);
      end
    end
    if (!w_pick_valid) begin
      for (int k = 0; k < N_LIGHTS; k++) begin
        w_rr = (w_rr == AW'(N_LIGHTS - 1)) ? '0 : w_rr + AW'(1);
        if (!w_pick_valid && !force_reds[w_rr]) begin
          w_pick_valid = 1'b1;
          w_pick       = w_rr;
        end
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_active_next = r_active;
    w_flash_next  = r_flash;
    if (tick) begin
      if (attention) begin
        w_state_next = S_FLASH;
        w_flash_next = (r_state == S_FLASH) ? ~r_flash : 1'b1;
      end else begin
        case (r_state)
          S_CLEAR: begin
            if (r_timer == CLEAR_END) begin
              if (w_pick_valid) begin
                w_state_next  = S_GREEN;
                w_active_next = w_pick;
              end else begin
                w_state_next = S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (w_any_free) w_state_next = S_CLEAR;
          end
          S_GREEN: begin
            if (force_reds[r_active] ||
                (w_preempt && (r_timer >= MIN_END)) ||
                ((r_timer == GREEN_END) && !preferentials[r_active]))
              w_state_next = S_YELLOW;
          end
          S_YELLOW: begin
            if (r_timer == YELLOW_END) w_state_next = S_CLEAR;
          end
          S_FLASH: begin
            w_state_next = S_CLEAR;
            w_flash_next = 1'b0;
          end
          default: w_state_next = S_CLEAR;
        endcase
      end
    end
  end

  // A green still standing at its last tick is being extended, so the timer parks there.
  always_comb begin
    w_timer_next = r_timer;
    if (w_state_next != r_state) begin
      w_timer_next = '0;
    end else if (tick) begin
      if (!((r_state == S_GREEN) && (r_timer == GREEN_END)) && (r_timer != '1))
        w_timer_next = r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_CLEAR;
      r_active <= AW'(N_LIGHTS - 1);
      r_timer  <= '0;
      r_flash  <= 1'b0;
      r_leds   <= {N_LIGHTS{3'b100}};
    end else begin
      r_state  <= w_state_next;
      r_active <= w_active_next;
      r_timer  <= w_timer_next;
      r_flash  <= w_flash_next;
      r_leds   <= w_leds_next;
    end
  end

  assign leds   = r_leds;
  assign active = r_active;
  assign phase  = r_state;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Bench for traffic_sequencer: each scenario queues the expected {phase, active, leds}
// observation for every tick and compares the registered outputs after that tick.
`timescale 1ns/1ps
module tb_traffic_sequencer;

  localparam logic [2:0] P_C = 3'd0;
  localparam logic [2:0] P_G = 3'd1;
  localparam logic [2:0] P_Y = 3'd2;
  localparam logic [2:0] P_F = 3'd3;
  localparam logic [2:0] P_H = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick = 1'b0;
  logic        attention = 1'b0;
  logic [3:0]  force_reds = 4'b0000;
  logic [3:0]  preferentials = 4'b0000;
  logic [11:0] leds;
  logic [1:0]  active;
  logic [2:0]  phase;

  logic [16:0] exp_q[$];
  int total = 0;
  int bad = 0;

  traffic_sequencer #(
    .N_LIGHTS(4), .GREEN_TICKS(8), .MIN_GREEN_TICKS(3), .YELLOW_TICKS(3), .CLEAR_TICKS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .attention(attention),
    .force_reds(force_reds),
    .preferentials(preferentials),
    .leds(leds),
    .active(active),
    .phase(phase)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [11:0] exp_leds(input logic [2:0] ph, input logic [1:0] act, input logic yel);
    logic [11:0] v;
    logic [2:0]  hv;
    v = '0;
    for (int h = 3; h >= 0; h--) begin
      hv = 3'b100;
      if (ph == P_F) hv = {1'b0, yel, 1'b0};
      else if (h == int'(act) && ph == P_G) hv = 3'b001;
      else if (h == int'(act) && ph == P_Y) hv = 3'b010;
      v = {v[8:0], hv};
    end
    return v;
  endfunction

  task automatic push(input logic [2:0] ph, input logic [1:0] act, input int n, input logic yel);
    for (int i = 0; i < n; i++) exp_q.push_back({ph, act, exp_leds(ph, act, yel)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 1'b0; attention = 1'b0; force_reds = 4'b0000; preferentials = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // One tick every 4 clocks; outputs are sampled on the falling edge after the tick edge.
  task automatic tick_once();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] want;
    want = {P_C, 2'd3, 12'h924};
    do_reset();
    total++;
    if ({phase, active, leds} !== want) begin
      bad++;
      $display("FAIL reset_state: got=%05h want=%05h", {phase, active, leds}, want);
    end else $display("reset_state: phase=%0d active=%0d leds=%03h", phase, active, leds);
    repeat (6) @(negedge clk);
    total++;
    if ({phase, active, leds} !== want) begin
      bad++;
      $display("FAIL idle_no_tick: got=%05h want=%05h", {phase, active, leds}, want);
    end else $display("idle_no_tick: phase=%0d active=%0d leds=%03h", phase, active, leds);
  endtask

  task automatic test_rotation();
    logic [16:0] got, want;
    int s = 0;
    do_reset();
    push(P_C, 2'd3, 1, 1'b0);
    for (int h = 0; h < 4; h++) begin
      push(P_G, 2'(h), 8, 1'b0);
      push(P_Y, 2'(h), 3, 1'b0);
      push(P_C, 2'(h), 2, 1'b0);
    end
    push(P_G, 2'd0, 1, 1'b0);
    while (exp_q.size() > 0) begin
      tick_once();
      got = {phase, active, leds};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rotation step %0d: got=%05h want=%05h", s, got, want);
      end else $display("rotation step %0d: phase=%0d active=%0d leds=%03h", s, phase, active, leds);
      s++;
    end
  endtask

  task automatic test_force_red();
    logic [16:0] got, want;
    int s = 0;
    do_reset();
    force_reds = 4'b0100;
    push(P_C, 2'd3, 1, 1'b0);
    push(P_G, 2'd0, 8, 1'b0); push(P_Y, 2'd0, 3, 1'b0); push(P_C, 2'd0, 2, 1'b0);
    push(P_G, 2'd1, 8, 1'b0); push(P_Y, 2'd1, 3, 1'b0); push(P_C, 2'd1, 2, 1'b0);
    push(P_G, 2'd3, 8, 1'b0); push(P_Y, 2'd3, 3, 1'b0); push(P_C, 2'd3, 2, 1'b0);
    push(P_G, 2'd0, 1, 1'b0);
    while (exp_q.size() > 0) begin
      tick_once();
      got = {phase, active, leds};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL force_skip step %0d: got=%05h want=%05h", s, got, want);
      end else $display("force_skip step %0d: phase=%0d active=%0d leds=%03h", s, phase, active, leds);
      s++;
    end
    // Cut head 1's green two observations in: yellow follows on the very next tick.
    do_reset();
    s = 0;
    push(P_C, 2'd3, 1, 1'b0);
    push(P_G, 2'd0, 8, 1'b0); push(P_Y, 2'd0, 3, 1'b0); push(P_C, 2'd0, 2, 1'b0);
    push(P_G, 2'd1, 2, 1'b0); push(P_Y, 2'd1, 3, 1'b0); push(P_C, 2'd1, 2, 1'b0);
    push(P_G, 2'd2, 1, 1'b0);
    while (exp_q.size() > 0) begin
      if (s == 16) force_reds = 4'b0010;
      tick_once();
      got = {phase, active, leds};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL force_cut step %0d: got=%05h want=%05h", s, got, want);
      end else $display("force_cut step %0d: phase=%0d active=%0d leds=%03h", s, phase, active, leds);
      s++;
    end
  endtask

  task automatic test_preempt();
    logic [16:0] got, want;
    int s = 0;
    do_reset();
    push(P_C, 2'd3, 1, 1'b0);
    push(P_G, 2'd0, 3, 1'b0);  push(P_Y, 2'd0, 3, 1'b0); push(P_C, 2'd0, 2, 1'b0);
    push(P_G, 2'd3, 12, 1'b0); push(P_Y, 2'd3, 3, 1'b0); push(P_C, 2'd3, 2, 1'b0);
    push(P_G, 2'd0, 8, 1'b0);  push(P_Y, 2'd0, 3, 1'b0); push(P_C, 2'd0, 2, 1'b0);
    push(P_G, 2'd2, 8, 1'b0);  push(P_Y, 2'd2, 3, 1'b0); push(P_C, 2'd2, 2, 1'b0);
    push(P_G, 2'd3, 1, 1'b0);
    while (exp_q.size() > 0) begin
      if (s == 3)  preferentials = 4'b1000;
      if (s == 21) preferentials = 4'b0000;
      if (s == 39) preferentials = 4'b1100;
      if (s == 40) preferentials = 4'b0000;
      tick_once();
      got = {phase, active, leds};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL preempt step %0d: got=%05h want=%05h", s, got, want);
      end else $display("preempt step %0d: phase=%0d active=%0d leds=%03h", s, phase, active, leds);
      s++;
    end
  endtask

  task automatic test_attention();
    logic [16:0] got, want;
    int s = 0;
    do_reset();
    push(P_C, 2'd3, 1, 1'b0);
    push(P_G, 2'd0, 8, 1'b0);
    push(P_Y, 2'd0, 1, 1'b0);
    push(P_F, 2'd0, 1, 1'b1); push(P_F, 2'd0, 1, 1'b0);
    push(P_F, 2'd0, 1, 1'b1); push(P_F, 2'd0, 1, 1'b0);
    push(P_C, 2'd0, 2, 1'b0);
    push(P_G, 2'd1, 1, 1'b0);
    while (exp_q.size() > 0) begin
      if (s == 3) begin
        @(negedge clk); attention = 1'b1;
        @(negedge clk); attention = 1'b0;
      end
      if (s == 10) attention = 1'b1;
      if (s == 14) attention = 1'b0;
      tick_once();
      got = {phase, active, leds};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL attention step %0d: got=%05h want=%05h", s, got, want);
      end else $display("attention step %0d: phase=%0d active=%0d leds=%03h", s, phase, active, leds);
      s++;
    end
  endtask

  task automatic test_hold();
    logic [16:0] got, want;
    int s = 0;
    do_reset();
    force_reds = 4'b1111;
    push(P_C, 2'd3, 1, 1'b0);
    push(P_H, 2'd3, 3, 1'b0);
    push(P_C, 2'd3, 2, 1'b0);
    push(P_G, 2'd2, 1, 1'b0);
    while (exp_q.size() > 0) begin
      if (s == 4) force_reds = 4'b1011;
      tick_once();
      got = {phase, active, leds};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL hold step %0d: got=%05h want=%05h", s, got, want);
      end else $display("hold step %0d: phase=%0d active=%0d leds=%03h", s, phase, active, leds);
      s++;
    end
  endtask

  task automatic test_async_reset();
    logic [16:0] got, want;
    int s = 0;
    do_reset();
    push(P_C, 2'd3, 1, 1'b0);
    push(P_G, 2'd0, 3, 1'b0);
    while (exp_q.size() > 0) begin
      tick_once();
      got = {phase, active, leds};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL async_pre step %0d: got=%05h want=%05h", s, got, want);
      end else $display("async_pre step %0d: phase=%0d active=%0d leds=%03h", s, phase, active, leds);
      s++;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    want = {P_C, 2'd3, 12'h924};
    total++;
    if ({phase, active, leds} !== want) begin
      bad++;
      $display("FAIL async_assert: got=%05h want=%05h", {phase, active, leds}, want);
    end else $display("async_assert: phase=%0d active=%0d leds=%03h", phase, active, leds);
    @(negedge clk);
    rst_n = 1'b1;
    s = 0;
    push(P_C, 2'd3, 1, 1'b0);
    push(P_G, 2'd0, 1, 1'b0);
    while (exp_q.size() > 0) begin
      tick_once();
      got = {phase, active, leds};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL async_post step %0d: got=%05h want=%05h", s, got, want);
      end else $display("async_post step %0d: phase=%0d active=%0d leds=%03h", s, phase, active, leds);
      s++;
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_force_red();
    test_preempt();
    test_attention();
    test_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
